// File: rtl/flag_unit.sv
// flag_unit
//   Producer side of the branch-condition interface. Computes Zero/Overflow/
//   Negative for the execute-stage ALU result, tracks flag-setting entries
//   through MEM and WB, commits them architecturally at WB, and drives a
//   bypassed flags bus (youngest in-flight value wins per bit) to the branch
//   resolver. Multi-cycle flag-setting ops hold flags_ready low until their
//   result arrives on mc_done.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   ex_valid          EX instruction valid
//   ex_upd[2:0]       per-flag update mask {Z,V,N}
//   ex_sub            subtract (B operand inverted for the overflow rule)
//   ex_a_msb/ex_b_msb operand MSBs (B before inversion)
//   ex_result         ALU result
//   ex_mc             instruction is multi-cycle
//   mc_done           one-cycle pulse: multi-cycle result present on EX inputs
//   stall             freeze EX/MEM/WB advance
//   flush             kill EX and MEM entries
//   flags[3:0]        registered bypassed flags {0,Z,V,N}
//   flags_ready       all older flag-setting instructions are resolved
//   arch_flags[3:0]   committed flags {0,Z,V,N}
module flag_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [2:0]       ex_upd,
  input  logic             ex_sub,
  input  logic             ex_a_msb,
  input  logic             ex_b_msb,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_mc,
  input  logic             mc_done,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       flags,
  output logic             flags_ready,
  output logic [3:0]       arch_flags
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_WAIT_MC = 1'b1
  } state_t;

  // {Z,V,N} for one ALU result; overflow uses the effective (possibly inverted) B sign.
  function automatic logic [2:0] calc_zvn(input logic [WIDTH-1:0] res,
                                          input logic a_msb,
                                          input logic b_msb,
                                          input logic sub);
    logic b_eff;
    b_eff       = b_msb ^ sub;
    calc_zvn[2] = (res == {WIDTH{1'b0}});
    calc_zvn[1] = (a_msb == b_eff) && (res[WIDTH-1] != a_msb);
    calc_zvn[0] = res[WIDTH-1];
  endfunction

  // Replace only the bits selected by upd.
  function automatic logic [2:0] overlay(input logic [2:0] base,
                                         input logic [2:0] upd,
                                         input logic [2:0] val);
    overlay = (base & ~upd) | (val & upd);
  endfunction

  state_t     state_r;
  state_t     state_nxt_s;
  logic [2:0] mask_r;
  logic       hold_valid_r;
  logic [2:0] hold_zvn_r;
  logic       ready_r;

  logic       mem_valid_r;
  logic [2:0] mem_upd_r;
  logic [2:0] mem_zvn_r;
  logic       wb_valid_r;
  logic [2:0] wb_upd_r;
  logic [2:0] wb_zvn_r;
  logic [2:0] arch_r;
  logic [3:0] flags_r;

  logic [2:0] ex_zvn_s;
  logic       ex_ent_valid_s;
  logic [2:0] ex_ent_upd_s;
  logic [2:0] ex_ent_zvn_s;
  logic       mc_start_s;
  logic       hold_load_s;
  logic       advance_s;
  logic [2:0] merge_wb_s;
  logic [2:0] merge_mem_s;
  logic [2:0] merge_all_s;

  assign ex_zvn_s = calc_zvn(ex_result, ex_a_msb, ex_b_msb, ex_sub);
  // Flush overrides stall: the pipe moves so WB can still commit.
  assign advance_s = !stall || flush;

  // FSM state register plus multi-cycle mask, stalled-result hold and ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      mask_r       <= 3'b000;
      hold_valid_r <= 1'b0;
      hold_zvn_r   <= 3'b000;
      ready_r      <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      if (mc_start_s) begin
        mask_r <= ex_upd;
      end else begin
        mask_r <= mask_r;
      end
      // Hold register only survives while stalled and not flushed.
      if (flush || !stall) begin
        hold_valid_r <= 1'b0;
      end else if (hold_load_s) begin
        hold_valid_r <= 1'b1;
        hold_zvn_r   <= ex_zvn_s;
      end else begin
        hold_valid_r <= hold_valid_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mc_start_s) begin
          state_nxt_s = ST_WAIT_MC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_MC: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (ex_ent_valid_s && !stall) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_MC;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Per-state outputs: the effective EX entry and FSM control strobes.
  always_comb begin
    ex_ent_valid_s = 1'b0;
    ex_ent_upd_s   = 3'b000;
    ex_ent_zvn_s   = ex_zvn_s;
    mc_start_s     = 1'b0;
    hold_load_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ex_valid && (ex_upd != 3'b000) && !flush) begin
          if (ex_mc) begin
            // Result not available yet; no entry until mc_done.
            mc_start_s = !stall;
          end else begin
            ex_ent_valid_s = 1'b1;
            ex_ent_upd_s   = ex_upd;
          end
        end else begin
          mc_start_s = 1'b0;
        end
      end
      ST_WAIT_MC: begin
        if (flush) begin
          ex_ent_valid_s = 1'b0;
        end else if (hold_valid_r) begin
          ex_ent_valid_s = 1'b1;
          ex_ent_upd_s   = mask_r;
          ex_ent_zvn_s   = hold_zvn_r;
        end else if (mc_done) begin
          ex_ent_valid_s = 1'b1;
          ex_ent_upd_s   = mask_r;
          hold_load_s    = stall;
        end else begin
          ex_ent_valid_s = 1'b0;
        end
      end
      default: begin
        ex_ent_valid_s = 1'b0;
      end
    endcase
  end

  // Bypass merge: architectural state overlaid by WB, MEM, then EX (youngest last).
  always_comb begin
    merge_wb_s  = wb_valid_r ? overlay(arch_r, wb_upd_r, wb_zvn_r) : arch_r;
    merge_mem_s = (mem_valid_r && !flush) ? overlay(merge_wb_s, mem_upd_r, mem_zvn_r)
                                          : merge_wb_s;
    merge_all_s = ex_ent_valid_s ? overlay(merge_mem_s, ex_ent_upd_s, ex_ent_zvn_s)
                                 : merge_mem_s;
  end

  // MEM/WB pipeline registers and architectural commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_r <= 1'b0;
      mem_upd_r   <= 3'b000;
      mem_zvn_r   <= 3'b000;
      wb_valid_r  <= 1'b0;
      wb_upd_r    <= 3'b000;
      wb_zvn_r    <= 3'b000;
      arch_r      <= 3'b000;
    end else if (advance_s) begin
      if (wb_valid_r) begin
        arch_r <= overlay(arch_r, wb_upd_r, wb_zvn_r);
      end else begin
        arch_r <= arch_r;
      end
      wb_valid_r  <= mem_valid_r && !flush;
      wb_upd_r    <= mem_upd_r;
      wb_zvn_r    <= mem_zvn_r;
      mem_valid_r <= ex_ent_valid_s;
      mem_upd_r   <= ex_ent_upd_s;
      mem_zvn_r   <= ex_ent_zvn_s;
    end else begin
      mem_valid_r <= mem_valid_r;
      wb_valid_r  <= wb_valid_r;
      arch_r      <= arch_r;
    end
  end

  // Registered bypassed flags bus (one cycle behind the merge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= 4'b0000;
    end else begin
      flags_r <= {1'b0, merge_all_s};
    end
  end

  assign flags       = flags_r;
  assign flags_ready = ready_r;
  assign arch_flags  = {1'b0, arch_r};

endmodule

// File: tb/tb_flag_unit.sv
module tb_flag_unit;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ex_valid = 1'b0;
  logic [2:0]   ex_upd = 3'b000;
  logic         ex_sub = 1'b0;
  logic         ex_a_msb = 1'b0;
  logic         ex_b_msb = 1'b0;
  logic [W-1:0] ex_result = '0;
  logic         ex_mc = 1'b0;
  logic         mc_done = 1'b0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   flags;
  logic         flags_ready;
  logic [3:0]   arch_flags;

  flag_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_upd(ex_upd),
    .ex_sub(ex_sub), .ex_a_msb(ex_a_msb), .ex_b_msb(ex_b_msb),
    .ex_result(ex_result), .ex_mc(ex_mc), .mc_done(mc_done),
    .stall(stall), .flush(flush), .flags(flags),
    .flags_ready(flags_ready), .arch_flags(arch_flags)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit model_on = 1'b0;

  // Reference model: committed flags, two in-flight slots (0 = MEM, 1 = WB),
  // and the pending multi-cycle op.
  logic [2:0] m_arch;
  bit         pv[2];
  logic [2:0] pu[2];
  logic [2:0] pf[2];
  bit         m_pend, m_held;
  logic [2:0] m_mask, m_heldf;
  logic [3:0] e_flags, e_arch;
  logic       e_ready;
  int         mc_wait = 0;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, act, exp);
    end
  endtask

  // Signed-arithmetic view of the ALU: returns {Z,V,N, result}.
  function automatic logic [18:0] alu(input logic [15:0] a, input logic [15:0] b, input bit sub);
    int sa, sb, r;
    logic [15:0] res;
    logic z, v, n;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    r   = sub ? (sa - sb) : (sa + sb);
    res = r[15:0];
    v   = (r > 32767) || (r < -32768);
    z   = (res == 16'h0000);
    n   = res[15];
    return {z, v, n, res};
  endfunction

  function automatic logic [2:0] apply_upd(input logic [2:0] base, input logic [2:0] upd,
                                           input logic [2:0] val);
    logic [2:0] r;
    r = base;
    for (int i = 0; i < 3; i++) begin
      if (upd[i]) r[i] = val[i];
    end
    return r;
  endfunction

  task automatic model_reset();
    m_arch = 3'b000;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pu[i] = 3'b000; pf[i] = 3'b000;
    end
    m_pend = 1'b0; m_held = 1'b0; m_mask = 3'b000; m_heldf = 3'b000;
    e_flags = 4'b0000; e_arch = 4'b0000; e_ready = 1'b1;
  endtask

  // Advance the model by one clock edge using the inputs just driven.
  task automatic model_step(input logic [2:0] zvn, input bit v, input logic [2:0] upd,
                            input bit mc, input bit done, input bit stl, input bit fl);
    bit ev;
    logic [2:0] eu, ef, mg;
    ev = 1'b0; eu = 3'b000; ef = zvn;
    if (!m_pend) begin
      if (v && upd != 3'b000 && !fl && !mc) begin ev = 1'b1; eu = upd; end
    end else if (!fl) begin
      if (m_held) begin ev = 1'b1; eu = m_mask; ef = m_heldf; end
      else if (done) begin ev = 1'b1; eu = m_mask; end
    end
    mg = m_arch;
    if (pv[1]) mg = apply_upd(mg, pu[1], pf[1]);
    if (pv[0] && !fl) mg = apply_upd(mg, pu[0], pf[0]);
    if (ev) mg = apply_upd(mg, eu, ef);
    e_flags = {1'b0, mg};
    if (!stl || fl) begin
      if (pv[1]) m_arch = apply_upd(m_arch, pu[1], pf[1]);
      pv[1] = pv[0] && !fl; pu[1] = pu[0]; pf[1] = pf[0];
      pv[0] = ev; pu[0] = eu; pf[0] = ef;
    end
    if (!m_pend) begin
      if (v && mc && upd != 3'b000 && !stl && !fl) begin
        m_pend = 1'b1; m_mask = upd; m_held = 1'b0;
      end
    end else if (fl) begin
      m_pend = 1'b0; m_held = 1'b0;
    end else if (m_held) begin
      if (!stl) begin m_pend = 1'b0; m_held = 1'b0; end
    end else if (done) begin
      if (stl) begin m_held = 1'b1; m_heldf = zvn; end
      else m_pend = 1'b0;
    end
    e_ready = !m_pend;
    e_arch = {1'b0, m_arch};
  endtask

  task automatic drive(input bit v, input logic [2:0] upd, input bit sub,
                       input logic [15:0] a, input logic [15:0] b,
                       input bit mc, input bit done, input bit stl, input bit fl);
    logic [18:0] r;
    @(negedge clk);
    r = alu(a, b, sub);
    ex_valid = v; ex_upd = upd; ex_sub = sub;
    ex_a_msb = a[15]; ex_b_msb = b[15]; ex_result = r[15:0];
    ex_mc = mc; mc_done = done; stall = stl; flush = fl;
    model_step(r[18:16], v, upd, mc, done, stl, fl);
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_inputs();
    ex_valid = 1'b0; ex_upd = 3'b000; ex_sub = 1'b0; ex_a_msb = 1'b0;
    ex_b_msb = 1'b0; ex_result = '0; ex_mc = 1'b0; mc_done = 1'b0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic apply_reset();
    model_on = 1'b0;
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_on = 1'b1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Every-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    if (model_on) begin
      chk("cmp_flags", flags, e_flags);
      chk("cmp_ready", {3'b000, flags_ready}, {3'b000, e_ready});
      chk("cmp_arch", arch_flags, e_arch);
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    apply_reset();
    after_edge();
    chk("rst_flags", flags, 4'b0000);
    chk("rst_ready", {3'b000, flags_ready}, 4'b0001);
    chk("rst_arch", arch_flags, 4'b0000);

    // ADD 0x7FFF + 0x0001 -> 0x8000: V and N set.
    drive(1'b1, 3'b111, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("add_flags", flags, 4'b0011);
    idle();
    idle();
    after_edge();
    chk("add_arch", arch_flags, 4'b0011);

    // SUB equal operands, Z-only update.
    apply_reset();
    drive(1'b1, 3'b100, 1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("sub_flags", flags, 4'b0100);
    idle();
    idle();
    after_edge();
    chk("sub_arch", arch_flags, 4'b0100);

    // Back-to-back Z-only then N-only.
    apply_reset();
    drive(1'b1, 3'b100, 1'b1, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("b2b_z", flags, 4'b0100);
    drive(1'b1, 3'b001, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("b2b_zn", flags, 4'b0101);

    // Flush with WB = N-only entry and MEM = Z-only entry.
    apply_reset();
    drive(1'b1, 3'b001, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'b100, 1'b1, 16'h0042, 16'h0042, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
    after_edge();
    chk("flush_flags", flags, 4'b0001);
    chk("flush_arch", arch_flags, 4'b0001);

    // Multi-cycle op, mc_done five cycles after issue with result 0.
    apply_reset();
    drive(1'b1, 3'b111, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("mc_ready_lo", {3'b000, flags_ready}, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      idle();
      after_edge();
      chk("mc_ready_lo", {3'b000, flags_ready}, 4'b0000);
    end
    drive(1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
    after_edge();
    chk("mc_ready_hi", {3'b000, flags_ready}, 4'b0001);
    chk("mc_flags", flags, 4'b0100);

    // Asynchronous reset while waiting on a multi-cycle op under stall.
    apply_reset();
    drive(1'b1, 3'b111, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    idle();
    idle();
    drive(1'b1, 3'b111, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 3'b000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    model_on = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst_flags", flags, 4'b0000);
    chk("arst_ready", {3'b000, flags_ready}, 4'b0001);
    chk("arst_arch", arch_flags, 4'b0000);
    clear_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_on = 1'b1;
    drive(1'b1, 3'b100, 1'b1, 16'h0005, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);
    after_edge();
    chk("arst_post_flags", flags, 4'b0100);
    chk("arst_post_ready", {3'b000, flags_ready}, 4'b0001);

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      bit v, mc, dn, st, fl, sb;
      logic [2:0] u;
      logic [15:0] a, b;
      v  = ($urandom_range(0, 3) != 0);
      u  = 3'($urandom_range(0, 7));
      sb = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        a = b;
        sb = 1'b1;
      end
      st = ($urandom_range(0, 5) == 0);
      fl = ($urandom_range(0, 11) == 0);
      mc = 1'b0;
      dn = 1'b0;
      if (!m_pend) begin
        mc = ($urandom_range(0, 7) == 0);
        mc_wait = $urandom_range(0, 6);
      end else if (!m_held) begin
        if (mc_wait == 0) dn = 1'b1;
        else mc_wait--;
      end
      drive(v, u, sb, a, b, mc, dn, st, fl);
    end
    idle();
    idle();
    idle();
    after_edge();
    model_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
